// File: rtl/clock_monitor.sv
// clock_monitor: counts monitored-clock edges per gate window, range-checks them and drives a debounced fault.
// Define CLOCK_MONITOR_STUCK_DET_EN to add an idle-cycle stuck-clock detector.
module clock_monitor #(
    parameter int CNT_W        = 16,
    parameter int GATE_CYCLES  = 4096,
    parameter int EXP_MIN      = 126,
    parameter int EXP_MAX      = 130,
    parameter int GOOD_WINDOWS = 2,
    parameter int BAD_WINDOWS  = 2,
    parameter int STUCK_CYCLES = 256
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_mon_clk,
    input  logic             i_pll_locked,
    output logic [CNT_W-1:0] o_count,
    output logic             o_valid,
    output logic             o_in_range,
    output logic             o_fault
);
    localparam int WIN_W = $clog2(GATE_CYCLES);
    localparam int GS_W  = $clog2(GOOD_WINDOWS + 1);
    localparam int BS_W  = $clog2(BAD_WINDOWS + 1);
    typedef enum logic {WAIT_LOCK, MEASURE} state_e;
    state_e           state_q, state_d;
    logic [2:0]       mon_q;
    logic [1:0]       lock_q;
    logic [WIN_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, count_q, count_d, final_cnt;
    logic [GS_W-1:0]  good_q, good_d;
    logic [BS_W-1:0]  bad_q, bad_d;
    logic             valid_q, valid_d, in_range_q, in_range_d, fault_q, fault_d;
    logic             mon_edge, lock_s, measuring, terminal, good_win, stuck;
    assign mon_edge  = mon_q[1] & ~mon_q[2];
    assign lock_s    = lock_q[1];
    assign measuring = (state_q == MEASURE) && lock_s;
    assign terminal  = measuring && (win_q == WIN_W'(GATE_CYCLES - 1));
    assign final_cnt = (mon_edge && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    assign good_win  = (final_cnt >= CNT_W'(EXP_MIN)) && (final_cnt <= CNT_W'(EXP_MAX));
`ifdef CLOCK_MONITOR_STUCK_DET_EN
    localparam int IDLE_W = $clog2(STUCK_CYCLES + 1);
    logic [IDLE_W-1:0] idle_q, idle_d;
    assign idle_d = (!measuring || mon_edge) ? '0 :
                    (idle_q == IDLE_W'(STUCK_CYCLES)) ? idle_q : idle_q + 1'b1;
    assign stuck  = idle_d == IDLE_W'(STUCK_CYCLES);
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) idle_q <= '0;
        else       idle_q <= idle_d;
    end
`else
    assign stuck = 1'b0;
`endif
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= WAIT_LOCK;
        else       state_q <= state_d;
    end
    // Lock loss aborts from any MEASURE cycle, so the next state depends only on lock_s.
    always_comb begin
        state_d = lock_s ? MEASURE : WAIT_LOCK;
    end
    always_comb begin
        win_d      = measuring ? (terminal ? '0 : win_q + 1'b1) : '0;
        cnt_d      = (measuring && !terminal) ? final_cnt : '0;
        count_d    = terminal ? final_cnt : count_q;
        in_range_d = terminal ? good_win : in_range_q;
        valid_d    = terminal;
        good_d     = !measuring ? '0 : !terminal ? good_q : !good_win ? '0 :
                     (good_q == GS_W'(GOOD_WINDOWS)) ? good_q : good_q + 1'b1;
        bad_d      = !measuring ? '0 : !terminal ? bad_q : good_win ? '0 :
                     (bad_q == BS_W'(BAD_WINDOWS)) ? bad_q : bad_q + 1'b1;
        fault_d    = !measuring ? 1'b1 : !terminal ? fault_q :
                     (good_d == GS_W'(GOOD_WINDOWS)) ? 1'b0 :
                     (bad_d == BS_W'(BAD_WINDOWS)) ? 1'b1 : fault_q;
        if (stuck) begin
            good_d  = '0;
            bad_d   = BS_W'(BAD_WINDOWS);
            fault_d = 1'b1;
        end
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mon_q      <= '0;
            lock_q     <= '0;
            win_q      <= '0;
            cnt_q      <= '0;
            count_q    <= '0;
            good_q     <= '0;
            bad_q      <= '0;
            valid_q    <= 1'b0;
            in_range_q <= 1'b0;
            fault_q    <= 1'b1;
        end else begin
            mon_q      <= {mon_q[1:0], i_mon_clk};
            lock_q     <= {lock_q[0], i_pll_locked};
            win_q      <= win_d;
            cnt_q      <= cnt_d;
            count_q    <= count_d;
            good_q     <= good_d;
            bad_q      <= bad_d;
            valid_q    <= valid_d;
            in_range_q <= in_range_d;
            fault_q    <= fault_d;
        end
    end
    assign o_count    = count_q;
    assign o_valid    = valid_q;
    assign o_in_range = in_range_q;
    assign o_fault    = fault_q;
endmodule

// File: tb/tb_clock_monitor.sv
// tb_clock_monitor: directed windows with a scoreboard of expected count/range/fault per o_valid.
// Monitored clock edges are phase-aligned to the 64-cycle windows so every window count is exact.
module tb_clock_monitor;
    logic        clk = 1'b0;
    logic        rst, mon, lock;
    logic [15:0] o_count;
    logic        o_valid, o_in_range, o_fault;
    typedef struct packed {logic [15:0] cnt; logic rng; logic flt;} exp_t;
    exp_t q[$];
    int   errors = 0, checks = 0;
    int   gc = 0, per = 8, per_next = 8;
`ifdef CLOCK_MONITOR_STUCK_DET_EN
    localparam logic STK = 1'b1;
`else
    localparam logic STK = 1'b0;
`endif

    clock_monitor #(
        .CNT_W(16), .GATE_CYCLES(64), .EXP_MIN(7), .EXP_MAX(9),
        .GOOD_WINDOWS(2), .BAD_WINDOWS(2), .STUCK_CYCLES(32)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_mon_clk(mon), .i_pll_locked(lock),
        .o_count(o_count), .o_valid(o_valid), .o_in_range(o_in_range), .o_fault(o_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Period changes only at window-aligned points (gc % 64 == 1), where both waveforms rise.
    task automatic tick();
        @(negedge clk);
        gc++;
        if (gc % 64 == 1) per = per_next;
        mon = (per != 0) && (((gc + 63) % per) < per / 2);
    endtask

    task automatic push_exp(input int c, input logic r, input logic f);
        exp_t e;
        e.cnt = 16'(c);
        e.rng = r;
        e.flt = f;
        q.push_back(e);
    endtask

    task automatic window(input int p, input int c, input logic r, input logic f);
        per_next = p;
        push_exp(c, r, f);
        do tick(); while (gc % 64 != 0);
    endtask

    task automatic release_rst();
        rst = 1'b0;
        gc  = 0;
        mon = 1'b0;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (o_valid === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got o_count=%0d expected no o_valid", o_count);
                end else begin
                    e = q.pop_front();
                    check("count", 32'(o_count), 32'(e.cnt));
                    check("in_range", 32'(o_in_range), 32'(e.rng));
                    check("fault", 32'(o_fault), 32'(e.flt));
                end
            end
        end
    end

    initial begin
        rst = 1'b1; lock = 1'b1; mon = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_fault", 32'(o_fault), 1);
        check("rst_count", 32'(o_count), 0);
        check("rst_valid", 32'(o_valid), 0);
        check("rst_in_range", 32'(o_in_range), 0);
        release_rst();
        window(8, 8, 1, 1); window(8, 8, 1, 0); window(8, 8, 1, 0);
        window(4, 16, 0, 0); window(4, 16, 0, 1); window(4, 16, 0, 1);
        window(8, 8, 1, 1); window(4, 16, 0, 1); window(8, 8, 1, 1); window(4, 16, 0, 1);
        window(8, 8, 1, 1); window(8, 8, 1, 0);
        window(4, 16, 0, 0); window(8, 8, 1, 0); window(4, 16, 0, 0); window(8, 8, 1, 0);
        repeat (20) tick();
        lock = 1'b0;
        tick(); tick();
        check("lock_fault_early", 32'(o_fault), 0);
        tick();
        check("lock_fault", 32'(o_fault), 1);
        check("lock_count_hold", 32'(o_count), 8);
        check("lock_range_hold", 32'(o_in_range), 1);
        while (gc % 64 != 0) tick();
        lock = 1'b1;
        window(8, 8, 1, 1); window(8, 8, 1, 0);
        repeat (30) tick();
        check("pre_rst_count", 32'(o_count), 8);
        rst = 1'b1;
        #1;
        check("async_rst_fault", 32'(o_fault), 1);
        check("async_rst_count", 32'(o_count), 0);
        check("async_rst_valid", 32'(o_valid), 0);
        check("async_rst_in_range", 32'(o_in_range), 0);
        tick();
        release_rst();
        window(8, 8, 1, 1); window(8, 8, 1, 0);
        per_next = 0;
        push_exp(0, 0, STK);
        repeat (27) tick();
        check("stuck_pre", 32'(o_fault), 0);
        tick();
        check("stuck_fault", 32'(o_fault), 32'(STK));
        while (gc % 64 != 0) tick();
        window(0, 0, 0, 1);
        for (int i = 0; i < 300 && q.size() > 0; i++) tick();
        check("drain_pending", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
